// File: rtl/gate_actuator.sv
// Level-crossing barrier sequencer: pre-warning, motor drive with a dead cycle on reversal,
// debounced end-of-travel switches, lamp flashing and sticky fault reporting.

module gate_actuator_limit #(
  parameter int SETTLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(SETTLE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (!sync[1])                cnt <= '0;
      else if (cnt != CW'(SETTLE)) cnt <= cnt + 1'b1;
    end
  end

  assign stable = (cnt == CW'(SETTLE));
endmodule

module gate_actuator #(
  parameter int PREWARN    = 500,
  parameter int TRAVEL_MAX = 2000,
  parameter int FLASH_DIV  = 250,
  parameter int SETTLE     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic gate,
  input  logic red_light,
  input  logic limit_up,
  input  logic limit_down,
  output logic motor_down,
  output logic motor_up,
  output logic lamp_l,
  output logic lamp_r,
  output logic bell,
  output logic gate_closed,
  output logic fault
);
  localparam int PW = (PREWARN    > 1) ? $clog2(PREWARN)    : 1;
  localparam int TW = (TRAVEL_MAX > 1) ? $clog2(TRAVEL_MAX) : 1;
  localparam int FW = (FLASH_DIV  > 1) ? $clog2(FLASH_DIV)  : 1;

  typedef enum logic [2:0] {OPEN, WARN, LOWERING, CLOSED, RAISING, FAULT} state_t;

  state_t        state, state_n;
  logic          gate_q, enable_q, red_q;
  logic [PW-1:0] warn_cnt;
  logic [TW-1:0] trav_cnt;
  logic [FW-1:0] flash_cnt;
  logic [1:0]    lim_ok;
  logic          up_ok, dn_ok, reverse, flash_n, timeout;

  gate_actuator_limit #(.SETTLE(SETTLE)) u_lim [1:0] (
    .clk    (clk),
    .reset  (reset),
    .raw    ({limit_up, limit_down}),
    .stable (lim_ok)
  );

  assign up_ok   = lim_ok[1];
  assign dn_ok   = lim_ok[0];
  assign timeout = (state == LOWERING || state == RAISING) && (trav_cnt == TW'(TRAVEL_MAX - 1));

  // Priority: fault conditions, then gate command, then limit acceptance.
  always_comb begin
    state_n = state;
    reverse = 1'b0;
    case (state)
      OPEN:     if (gate_q && enable_q) state_n = WARN;
      WARN:     if (!gate_q) state_n = OPEN;
                else if (warn_cnt == PW'(PREWARN - 1)) state_n = LOWERING;
      LOWERING: if (!gate_q) begin
                  state_n = RAISING;
                  reverse = 1'b1;
                end else if (dn_ok) state_n = CLOSED;
      CLOSED:   if (!gate_q) state_n = RAISING;
      RAISING:  if (gate_q) begin
                  state_n = LOWERING;
                  reverse = 1'b1;
                end else if (up_ok) state_n = OPEN;
      FAULT:    state_n = FAULT;
      default:  state_n = FAULT;
    endcase
    if (state != FAULT && ((up_ok && dn_ok) || timeout)) begin
      state_n = FAULT;
      reverse = 1'b0;
    end
  end

  assign flash_n = (state_n != OPEN) || red_q;

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= OPEN;
      gate_q      <= 1'b0;
      enable_q    <= 1'b0;
      red_q       <= 1'b0;
      warn_cnt    <= '0;
      trav_cnt    <= '0;
      flash_cnt   <= '0;
      motor_down  <= 1'b0;
      motor_up    <= 1'b0;
      lamp_l      <= 1'b0;
      lamp_r      <= 1'b0;
      bell        <= 1'b0;
      gate_closed <= 1'b0;
      fault       <= 1'b0;
    end else begin
      gate_q   <= gate;
      enable_q <= enable;
      red_q    <= red_light;
      state    <= state_n;

      warn_cnt <= (state == WARN && state_n == WARN) ? warn_cnt + 1'b1 : '0;

      // A reversal holds both motors off for one cycle; the timer only runs while driving.
      if (state_n != state)           trav_cnt <= '0;
      else if (motor_down || motor_up) trav_cnt <= trav_cnt + 1'b1;

      motor_down  <= (state_n == LOWERING) && !reverse;
      motor_up    <= (state_n == RAISING) && !reverse;
      bell        <= (state_n == WARN) || (state_n == LOWERING) || (state_n == FAULT);
      gate_closed <= (state_n == CLOSED);
      fault       <= (state_n == FAULT);

      if (!flash_n) begin
        flash_cnt <= '0;
        lamp_l    <= 1'b0;
        lamp_r    <= 1'b0;
      end else if (!(lamp_l || lamp_r)) begin
        flash_cnt <= '0;
        lamp_l    <= 1'b1;
        lamp_r    <= 1'b0;
      end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
        flash_cnt <= '0;
        lamp_l    <= ~lamp_l;
        lamp_r    <= ~lamp_r;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gate_actuator.sv
// Scoreboard bench for gate_actuator: expected output vectors {md,mu,lamp_l,lamp_r,bell,closed,fault}
// are queued as each cycle's stimulus is driven and popped when the DUT output is sampled.

module tb_gate_actuator;
  localparam int PW = 8, TM = 40, FD = 4, ST = 3;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b1, gate = 1'b0, red_light = 1'b0;
  logic limit_up = 1'b0, limit_down = 1'b0;
  logic motor_down, motor_up, lamp_l, lamp_r, bell, gate_closed, fault;
  logic [6:0] cur, obs, e;
  logic [6:0] exp_q[$];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  gate_actuator #(.PREWARN(PW), .TRAVEL_MAX(TM), .FLASH_DIV(FD), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gate(gate), .red_light(red_light),
    .limit_up(limit_up), .limit_down(limit_down), .motor_down(motor_down), .motor_up(motor_up),
    .lamp_l(lamp_l), .lamp_r(lamp_r), .bell(bell), .gate_closed(gate_closed), .fault(fault)
  );

  assign cur = {motor_down, motor_up, lamp_l, lamp_r, bell, gate_closed, fault};

  // k = cycles since flashing began, negative when the lamps should be dark
  function automatic logic [6:0] ev(bit md, bit mu, int k, bit b, bit gc, bit f);
    logic ll, lr;
    ll = 1'b0;
    lr = 1'b0;
    if (k >= 0) begin
      ll = ((k / FD) % 2) == 0;
      lr = !ll;
    end
    return {md, mu, ll, lr, b, gc, f};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    obs = cur;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cur !== 7'd0) begin fails++; $display("FAIL reset_state got %b exp %b", cur, 7'd0); end
    reset = 1'b1;
    for (int t = 0; t < 16; t++) begin
      red_light = (t < 12);
      e = (t >= 1 && t <= 12) ? ev(0, 0, t - 1, 0, 0, 0) : 7'd0;
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL red_flash t=%0d got %b exp %b", t, obs, e); end
    end
  endtask

  task automatic test_close_open();
    for (int t = 0; t < 30; t++) begin
      gate       = (t < 19);
      limit_down = (t >= 11 && t < 19);
      limit_up   = (t >= 22 && t < 28);
      if (t == 0)       e = 7'd0;
      else if (t <= 8)  e = ev(0, 0, t - 1, 1, 0, 0);
      else if (t <= 15) e = ev(1, 0, t - 1, 1, 0, 0);
      else if (t <= 19) e = ev(0, 0, t - 1, 0, 1, 0);
      else if (t <= 26) e = ev(0, 1, t - 1, 0, 0, 0);
      else              e = 7'd0;
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL close_open t=%0d got %b exp %b", t, obs, e); end
    end
  endtask

  task automatic test_abort();
    for (int t = 0; t < 8; t++) begin
      gate = (t < 4);
      e = (t >= 1 && t <= 4) ? ev(0, 0, t - 1, 1, 0, 0) : 7'd0;
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL warn_abort t=%0d got %b exp %b", t, obs, e); end
    end
    for (int t = 0; t < 22; t++) begin
      gate     = (t < 11);
      limit_up = (t >= 14 && t < 20);
      if (t == 0)       e = 7'd0;
      else if (t <= 8)  e = ev(0, 0, t - 1, 1, 0, 0);
      else if (t <= 11) e = ev(1, 0, t - 1, 1, 0, 0);
      else if (t == 12) e = ev(0, 0, t - 1, 0, 0, 0);
      else if (t <= 18) e = ev(0, 1, t - 1, 0, 0, 0);
      else              e = 7'd0;
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL reversal t=%0d got %b exp %b", t, obs, e); end
    end
  endtask

  task automatic test_timeout();
    for (int t = 0; t < 63; t++) begin
      gate = (t < 52) || (t >= 55 && t < 58);
      if (t == 0)       e = 7'd0;
      else if (t <= 8)  e = ev(0, 0, t - 1, 1, 0, 0);
      else if (t <= 48) e = ev(1, 0, t - 1, 1, 0, 0);
      else              e = ev(0, 0, t - 1, 1, 0, 1);
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL timeout t=%0d got %b exp %b", t, obs, e); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cur !== 7'd0) begin fails++; $display("FAIL fault_reset got %b exp %b", cur, 7'd0); end
    @(negedge clk);
    gate = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_glitch_conflict();
    for (int t = 0; t < 29; t++) begin
      gate       = 1'b1;
      limit_down = (t == 10 || t == 11 || t >= 21);
      limit_up   = (t >= 21);
      if (t == 0)       e = 7'd0;
      else if (t <= 8)  e = ev(0, 0, t - 1, 1, 0, 0);
      else if (t <= 25) e = ev(1, 0, t - 1, 1, 0, 0);
      else              e = ev(0, 0, t - 1, 1, 0, 1);
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL glitch_conflict t=%0d got %b exp %b", t, obs, e); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cur !== 7'd0) begin fails++; $display("FAIL conflict_reset got %b exp %b", cur, 7'd0); end
    @(negedge clk);
    gate = 1'b0;
    limit_up = 1'b0;
    limit_down = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_enable();
    for (int t = 0; t < 28; t++) begin
      enable     = (t >= 6 && t < 17);
      gate       = (t < 25);
      limit_down = (t >= 18 && t < 25);
      if (t <= 6)       e = 7'd0;
      else if (t <= 14) e = ev(0, 0, t - 7, 1, 0, 0);
      else if (t <= 22) e = ev(1, 0, t - 7, 1, 0, 0);
      else if (t <= 25) e = ev(0, 0, t - 7, 0, 1, 0);
      else              e = ev(0, 1, t - 7, 0, 0, 0);
      exp_q.push_back(e);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL enable t=%0d got %b exp %b", t, obs, e); end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cur !== 7'd0) begin fails++; $display("FAIL raising_reset got %b exp %b", cur, 7'd0); end
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_close_open();
    test_abort();
    test_timeout();
    test_glitch_conflict();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
